// File: rtl/me_stage.sv
// Memory-access stage: ALU results pass through, loads/stores go to the data-memory port.
// Latency: non-mem op 1 cycle; store 3 + gnt wait; load 4 + gnt wait + rvalid wait.
// Backpressure: me_stall holds the EX/ME register while a memory transaction is outstanding.
module me_stage #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ME_mem_ctrl,
    input  logic [1:0]    ME_wb_ctrl,
    input  logic [63:0]   ME_data,
    input  logic [63:0]   ME_addr,
    input  logic [4:0]    ME_dest,
    input  logic [1:0]    ME_tid,
    output logic          me_stall,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [63:0]   dmem_wdata,
    input  logic          dmem_gnt,
    input  logic          dmem_rvalid,
    input  logic [63:0]   dmem_rdata,
    output logic [1:0]    WB_wb_ctrl,
    output logic [63:0]   WB_data,
    output logic [4:0]    WB_dest,
    output logic [1:0]    WB_tid
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          mem_op;
    logic          hold_store;
    logic [1:0]    hold_wb;
    logic [63:0]   hold_data;
    logic [AW-1:0] hold_addr;
    logic [4:0]    hold_dest;
    logic [1:0]    hold_tid;
    logic [63:0]   load_data;
    logic          unused_addr_bits;

    assign mem_op           = ME_mem_ctrl | ME_wb_ctrl[0];
    assign unused_addr_bits = ^{ME_addr[63:AW+3], ME_addr[2:0]};

    always_comb begin
        state_nxt  = state;
        me_stall   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        case (state)
            IDLE: begin
                me_stall = mem_op;
                if (mem_op) state_nxt = REQ;
            end
            REQ: begin
                me_stall   = 1'b1;
                dmem_req   = 1'b1;
                dmem_we    = hold_store;
                dmem_addr  = hold_addr;
                dmem_wdata = hold_data;
                if (dmem_gnt) state_nxt = hold_store ? DONE : WAIT;
            end
            WAIT: begin
                me_stall = 1'b1;
                if (dmem_rvalid) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // While reset is low the upstream pipeline must not be frozen.
        if (!rst) me_stall = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            hold_store <= 1'b0;
            hold_wb    <= '0;
            hold_data  <= '0;
            hold_addr  <= '0;
            hold_dest  <= '0;
            hold_tid   <= '0;
            load_data  <= '0;
            WB_wb_ctrl <= '0;
            WB_data    <= '0;
            WB_dest    <= '0;
            WB_tid     <= '0;
        end else begin
            state      <= state_nxt;
            WB_wb_ctrl <= '0;
            WB_data    <= '0;
            WB_dest    <= '0;
            WB_tid     <= '0;
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        hold_store <= ME_mem_ctrl;
                        hold_wb    <= ME_wb_ctrl;
                        hold_data  <= ME_data;
                        hold_addr  <= ME_addr[AW+2:3];
                        hold_dest  <= ME_dest;
                        hold_tid   <= ME_tid;
                    end else begin
                        WB_wb_ctrl <= ME_wb_ctrl;
                        WB_data    <= ME_data;
                        WB_dest    <= ME_dest;
                        WB_tid     <= ME_tid;
                    end
                end
                WAIT: begin
                    if (dmem_rvalid) load_data <= dmem_rdata;
                end
                DONE: begin
                    // A store retires as a bubble; ME_* still shows the old op and is ignored.
                    if (!hold_store) begin
                        WB_wb_ctrl <= hold_wb;
                        WB_data    <= load_data;
                        WB_dest    <= hold_dest;
                        WB_tid     <= hold_tid;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_me_stage.sv
// Randomized bench for me_stage: a transaction-timeline model predicts every output each cycle.
module tb_me_stage;
    localparam int AW   = 10;
    localparam int LOGN = 8192;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ME_mem_ctrl;
    logic [1:0]    ME_wb_ctrl;
    logic [63:0]   ME_data;
    logic [63:0]   ME_addr;
    logic [4:0]    ME_dest;
    logic [1:0]    ME_tid;
    logic          me_stall;
    logic          dmem_req;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [63:0]   dmem_wdata;
    logic          dmem_gnt;
    logic          dmem_rvalid;
    logic [63:0]   dmem_rdata;
    logic [1:0]    WB_wb_ctrl;
    logic [63:0]   WB_data;
    logic [4:0]    WB_dest;
    logic [1:0]    WB_tid;

    always #5 clk = ~clk;

    me_stage #(.AW(AW)) dut (
        .clk(clk), .rst(rst),
        .ME_mem_ctrl(ME_mem_ctrl), .ME_wb_ctrl(ME_wb_ctrl), .ME_data(ME_data),
        .ME_addr(ME_addr), .ME_dest(ME_dest), .ME_tid(ME_tid),
        .me_stall(me_stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .WB_wb_ctrl(WB_wb_ctrl), .WB_data(WB_data), .WB_dest(WB_dest), .WB_tid(WB_tid)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // expectations for the current cycle, and the WB value the current cycle produces
    logic          exp_stall, exp_req, exp_we;
    logic [AW-1:0] exp_addr;
    logic [63:0]   exp_wdata;
    logic [1:0]    exp_wbc  = '0, pend_wbc  = '0;
    logic [63:0]   exp_wbd  = '0, pend_wbd  = '0;
    logic [4:0]    exp_dest = '0, pend_dest = '0;
    logic [1:0]    exp_tid  = '0, pend_tid  = '0;

    logic          log_stall [LOGN];
    logic          log_req   [LOGN];
    logic          log_we    [LOGN];
    logic [AW-1:0] log_addr  [LOGN];
    logic [1:0]    log_wbc   [LOGN];
    logic [63:0]   log_wbd   [LOGN];
    logic [4:0]    log_dest  [LOGN];
    logic [1:0]    log_tid   [LOGN];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("me_stall",   64'(me_stall),   64'(exp_stall));
            chk("dmem_req",   64'(dmem_req),   64'(exp_req));
            chk("dmem_we",    64'(dmem_we),    64'(exp_we));
            chk("dmem_addr",  64'(dmem_addr),  64'(exp_addr));
            chk("dmem_wdata", dmem_wdata,      exp_wdata);
            chk("WB_wb_ctrl", 64'(WB_wb_ctrl), 64'(exp_wbc));
            chk("WB_data",    WB_data,         exp_wbd);
            chk("WB_dest",    64'(WB_dest),    64'(exp_dest));
            chk("WB_tid",     64'(WB_tid),     64'(exp_tid));
        end
        if (cyc < LOGN) begin
            log_stall[cyc] = me_stall;  log_req[cyc]  = dmem_req;
            log_we[cyc]    = dmem_we;   log_addr[cyc] = dmem_addr;
            log_wbc[cyc]   = WB_wb_ctrl; log_wbd[cyc] = WB_data;
            log_dest[cyc]  = WB_dest;   log_tid[cyc]  = WB_tid;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        exp_wbc = pend_wbc; exp_wbd = pend_wbd; exp_dest = pend_dest; exp_tid = pend_tid;
    endtask

    task automatic no_mem_exp();
        exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
    endtask

    task automatic pend_bubble();
        pend_wbc = '0; pend_wbd = '0; pend_dest = '0; pend_tid = '0;
    endtask

    task automatic rand_me();
        ME_mem_ctrl = 1'($urandom); ME_wb_ctrl = 2'($urandom);
        ME_data = {$urandom, $urandom}; ME_addr = {$urandom, $urandom};
        ME_dest = 5'($urandom); ME_tid = 2'($urandom);
    endtask

    // Present one op; the bench's memory grants after g wait cycles and answers a load
    // r cycles after the first legal rvalid cycle.
    task automatic run_op(input logic st, input logic [1:0] wbc, input logic [63:0] data,
                          input logic [63:0] addr, input logic [4:0] dest, input logic [1:0] tid,
                          input int g, input int r, input logic [63:0] rd);
        logic mem;
        mem = st | wbc[0];
        step();
        rst = 1'b1;
        ME_mem_ctrl = st; ME_wb_ctrl = wbc; ME_data = data; ME_addr = addr;
        ME_dest = dest; ME_tid = tid;
        dmem_gnt = 1'($urandom); dmem_rvalid = 1'($urandom); dmem_rdata = {$urandom, $urandom};
        no_mem_exp();
        exp_stall = mem;
        if (!mem) begin
            pend_wbc = wbc; pend_wbd = data; pend_dest = dest; pend_tid = tid;
            return;
        end
        pend_bubble();
        for (int i = 0; i <= g; i++) begin
            step();
            dmem_gnt = (i == g); dmem_rvalid = 1'($urandom); dmem_rdata = {$urandom, $urandom};
            exp_stall = 1'b1; exp_req = 1'b1; exp_we = st;
            exp_addr = AW'(addr >> 3); exp_wdata = data;
        end
        if (!st) begin
            for (int j = 0; j <= r; j++) begin
                step();
                dmem_gnt = 1'b0; dmem_rvalid = (j == r);
                dmem_rdata = (j == r) ? rd : {$urandom, $urandom};
                no_mem_exp();
                exp_stall = 1'b1;
            end
        end
        step();
        dmem_gnt = 1'($urandom); dmem_rvalid = 1'($urandom); dmem_rdata = {$urandom, $urandom};
        no_mem_exp();
        if (!st) begin
            pend_wbc = wbc; pend_wbd = rd; pend_dest = dest; pend_tid = tid;
        end
    endtask

    task automatic settle();
        run_op(1'b0, 2'b00, 64'h0, 64'h0, 5'd0, 2'd0, 0, 0, 64'h0);
        @(negedge clk);
        #1;
    endtask

    // Load that is reset while waiting for its read data; a late rvalid must be ignored.
    task automatic load_abort(input int t0);
        int cnt;
        step();
        rst = 1'b1;
        ME_mem_ctrl = 1'b0; ME_wb_ctrl = 2'b11; ME_data = {$urandom, $urandom};
        ME_addr = {$urandom, $urandom}; ME_dest = 5'd12; ME_tid = 2'd3;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        no_mem_exp(); exp_stall = 1'b1; pend_bubble();
        step();
        dmem_gnt = 1'b1;
        exp_stall = 1'b1; exp_req = 1'b1; exp_we = 1'b0;
        exp_addr = AW'(ME_addr >> 3); exp_wdata = ME_data;
        for (int k = 0; k < 2; k++) begin
            step();
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
            no_mem_exp(); exp_stall = 1'b1;
        end
        for (int k = 0; k < 2; k++) begin
            step();
            rst = 1'b0; rand_me();
            dmem_gnt = 1'($urandom); dmem_rvalid = 1'($urandom); dmem_rdata = {$urandom, $urandom};
            no_mem_exp();
        end
        for (int k = 0; k < 5; k++) begin
            step();
            rst = 1'b1;
            ME_mem_ctrl = 1'b0; ME_wb_ctrl = 2'b00; ME_data = '0; ME_addr = '0;
            ME_dest = '0; ME_tid = '0;
            dmem_gnt = 1'b0; dmem_rvalid = (k == 0) ? 1'b1 : 1'($urandom);
            dmem_rdata = {$urandom, $urandom};
            no_mem_exp();
        end
        @(negedge clk);
        #1;
        cnt = 0;
        for (int c = t0 + 4; c <= t0 + 10; c++) cnt += int'(log_wbc[c] != 2'b00) + int'(log_wbd[c] != 64'h0);
        chk("abort_no_writeback", 64'(cnt), 64'd0);
        cnt = 0;
        for (int c = t0 + 6; c <= t0 + 10; c++) cnt += int'(log_stall[c]) + int'(log_req[c]);
        chk("abort_stays_idle", 64'(cnt), 64'd0);
    endtask

    initial begin
        int t0;
        int cnt;
        rand_me();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        no_mem_exp();

        // reset with random inputs
        for (int k = 0; k < 2; k++) begin
            step();
            chk_en = 1'b1;
            rand_me();
            dmem_gnt = 1'($urandom); dmem_rvalid = 1'($urandom); dmem_rdata = {$urandom, $urandom};
            no_mem_exp();
        end

        // ALU pass-through, back to back
        t0 = cyc + 1;
        for (int k = 0; k < 3; k++)
            run_op(1'b0, 2'b10, 64'h1234 + 64'(k), {$urandom, $urandom}, 5'd7, 2'd2, 0, 0, 64'h0);
        settle();
        chk("alu_wb_data0", log_wbd[t0+1], 64'h1234);
        chk("alu_wb_data1", log_wbd[t0+2], 64'h1235);
        chk("alu_wb_data2", log_wbd[t0+3], 64'h1236);
        chk("alu_wb_ctrl",  64'(log_wbc[t0+1]), 64'd2);
        chk("alu_wb_dest",  64'(log_dest[t0+2]), 64'd7);
        chk("alu_wb_tid",   64'(log_tid[t0+3]), 64'd2);
        cnt = 0;
        for (int c = t0; c <= t0 + 3; c++) cnt += int'(log_stall[c]);
        chk("alu_no_stall", 64'(cnt), 64'd0);

        // store, grant two cycles late
        t0 = cyc + 1;
        run_op(1'b1, 2'b00, 64'hDEADBEEF, 64'h40, 5'd3, 2'd0, 2, 0, 64'h0);
        settle();
        cnt = 0;
        for (int c = t0; c <= t0 + 5; c++) cnt += int'(log_req[c]);
        chk("store_req_cycles", 64'(cnt), 64'd3);
        cnt = 0;
        for (int c = t0; c <= t0 + 5; c++) cnt += int'(log_stall[c]);
        chk("store_stall_cycles", 64'(cnt), 64'd4);
        chk("store_addr", 64'(log_addr[t0+1]), 64'd8);
        chk("store_we",   64'(log_we[t0+3]), 64'd1);
        chk("store_wb_bubble", 64'(log_wbc[t0+5]), 64'd0);

        // load (immediate gnt, rvalid three cycles later) then a held ALU op
        t0 = cyc + 1;
        run_op(1'b0, 2'b11, {$urandom, $urandom}, {$urandom, $urandom}, 5'd5, 2'd1, 0, 2, 64'hCAFE);
        run_op(1'b0, 2'b10, 64'hA1, 64'h0, 5'd9, 2'd3, 0, 0, 64'h0);
        settle();
        chk("load_before_done", 64'(log_wbc[t0+5]), 64'd0);
        chk("load_wb_data", log_wbd[t0+6], 64'hCAFE);
        chk("load_wb_ctrl", 64'(log_wbc[t0+6]), 64'd3);
        chk("load_wb_dest", 64'(log_dest[t0+6]), 64'd5);
        chk("load_wb_tid",  64'(log_tid[t0+6]), 64'd1);
        chk("next_alu_data", log_wbd[t0+7], 64'hA1);
        chk("next_alu_dest", 64'(log_dest[t0+7]), 64'd9);

        // reset while a load waits for data
        load_abort(cyc + 1);

        // random traffic
        for (int n = 0; n < 300; n++) begin
            run_op(1'($urandom_range(0, 3) == 0), 2'($urandom), {$urandom, $urandom},
                   {$urandom, $urandom}, 5'($urandom), 2'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 3), {$urandom, $urandom});
        end
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/me_stage.md
Name: me_stage

Overview:
- Memory-access stage of the 4-thread, 64-bit pipeline.
- Consumes the outputs of the EX/ME pipeline register and performs loads and stores against a handshaked data-memory port.
- Presents registered results to the WB stage.
- Stalls the upstream pipeline while a memory transaction is outstanding.

Parameters:
- AW, 10, data-memory word-address width (64-bit words).

Ports:
- clk  input  1  pipeline clock
- rst  input  1  synchronous, active-low reset
- ME_mem_ctrl  input  1  1 = store
- ME_wb_ctrl  input  2  [1] = register write, [0] = mem-to-reg (load)
- ME_data  input  64  store data / ALU result
- ME_addr  input  64  byte address
- ME_dest  input  5  destination register
- ME_tid  input  2  thread id
- me_stall  output  1  upstream must hold the EX/ME register while high
- dmem_req  output  1  memory request
- dmem_we  output  1  1 = write
- dmem_addr  output  AW  word address, = ME_addr[AW+2:3] as captured
- dmem_wdata  output  64  store data
- dmem_gnt  input  1  request accepted this cycle
- dmem_rvalid  input  1  read data valid
- dmem_rdata  input  64  read data
- WB_wb_ctrl  output  2  registered wb_ctrl (00 = bubble)
- WB_data  output  64  load data or passed-through ALU result
- WB_dest  output  5  registered destination register
- WB_tid  output  2  registered thread id

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low: rst=0 sampled at posedge resets the block.
- Reset values:
  - All WB_* outputs = 0.
  - dmem_req = 0, dmem_we = 0, dmem_addr = 0, dmem_wdata = 0.
  - FSM = IDLE; holding registers = 0.
- Operation classes:
  - mem op = ME_mem_ctrl | ME_wb_ctrl[0].
  - ME_mem_ctrl and ME_wb_ctrl[0] both set: treat as store; WB_wb_ctrl = 00.
  - ME_addr[2:0] ignored. Upper bits above AW+2 ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, non-mem op:
  - At next posedge, WB_* <= ME_* (WB_data = ME_data).
  - me_stall = 0. Latency 1 cycle; back-to-back ops every cycle.
- IDLE, mem op:
  - Capture mem_ctrl, wb_ctrl, data, addr, dest, tid into holding registers; go to REQ.
  - me_stall = 1 combinationally this cycle. WB_* <= bubble (all 0).
- REQ:
  - dmem_req = 1; dmem_we = held store flag; dmem_addr and dmem_wdata driven from holding registers.
  - All dmem outputs stay stable until the cycle dmem_gnt = 1.
  - On gnt: store goes to DONE, load goes to WAIT.
  - dmem_req deasserts the cycle after gnt.
  - me_stall = 1; WB_* <= bubble.
- WAIT:
  - dmem_req = 0. On dmem_rvalid, capture dmem_rdata into the load register and go to DONE.
  - rvalid in the same cycle as gnt is ignored; memory read latency is ≥ 1 cycle after gnt.
  - me_stall = 1; WB_* <= bubble.
- DONE:
  - me_stall = 0, so upstream advances at this edge. ME_* inputs are ignored this cycle (they still hold the old op).
  - Load: WB_wb_ctrl <= held wb_ctrl, WB_data <= load data, WB_dest / WB_tid <= held values.
  - Store: WB_wb_ctrl <= 00, WB_data <= 0.
  - Next state IDLE.
- Latency (cycles from op presentation to WB valid): store 3 + gnt wait; load 4 + gnt wait + rvalid wait. No timeout.
- dmem_gnt or dmem_rvalid arriving in IDLE or DONE: ignored.
- Reset mid-transaction, in any state: FSM to IDLE, dmem_req drops the next cycle, holding registers cleared. An outstanding read response is discarded because rvalid is ignored in IDLE.
- Only one transaction is outstanding at a time; no buffering beyond the holding registers.

Test Plan:
- Reset: rst=0 for 2 cycles with random inputs -> all outputs 0, me_stall=0, dmem_req=0.
- ALU pass-through: ME_wb_ctrl=10, data=0x1234, dest=7, tid=2 on 3 consecutive cycles with distinct data -> WB shows each one cycle later, me_stall never asserts.
- Store with gnt delayed 2 cycles: addr=0x40, data=0xDEADBEEF -> dmem_req held 3 cycles, dmem_addr=8, dmem_we=1, wdata stable; me_stall high 4 cycles; WB bubble throughout; WB_wb_ctrl=00 after DONE.
- Load with gnt immediate, rvalid 3 cycles later: rdata=0xCAFE, dest=5, tid=1, wb_ctrl=11 -> WB_data=0xCAFE, WB_dest=5, WB_tid=1, WB_wb_ctrl=11 exactly one cycle after DONE; total 6 cycles from presentation.
- Load immediately followed by an ALU op held upstream -> ALU op appears at WB exactly one cycle after the load result; no op lost or duplicated.
- rst=0 asserted while in WAIT, then rvalid pulses after reset releases -> FSM stays IDLE, WB remains 0, no spurious write-back.
